// File: rtl/l2_ecc_pkg.sv
// SECDED helpers for the L2 bank ECC stage: codeword typedefs, encoder and syndrome mapping.
// Optional read-repair writeback is enabled by defining L2_BANK_ECC_WRITEBACK_EN.
package l2_ecc_pkg;

  localparam int unsigned MaxDw = 64;
  localparam int unsigned MaxCw = 72;

  typedef logic [MaxDw-1:0] data_max_t;
  typedef logic [MaxCw-1:0] cw_max_t;
  typedef logic [6:0]       syndrome_t;

`ifdef L2_BANK_ECC_WRITEBACK_EN
  typedef enum logic [1:0] {StIdle, StResp, StMerge, StWb} state_e;
`else
  typedef enum logic [1:0] {StIdle, StResp, StMerge} state_e;
`endif

  function automatic int unsigned par_width(input int unsigned dw);
    return (dw == 32) ? 7 : 8;
  endfunction

  // Codeword bit p is Hamming position p; bit 0 is overall parity; powers of two are checks.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned cnt = 0;
    int unsigned pos = 0;
    for (int unsigned p = 1; p < MaxCw; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bit index addressed by a syndrome, or -1 for a check bit / no error.
  function automatic int syn_to_bit(input syndrome_t s);
    int npow = 0;
    for (int j = 0; j < 7; j++) begin
      if ((syndrome_t'(1) << j) <= s) npow++;
    end
    if (s == '0 || (s & (s - syndrome_t'(1))) == '0) return -1;
    return int'(s) - npow - 1;
  endfunction

  function automatic cw_max_t secded_encode(input data_max_t data, input int unsigned dw);
    cw_max_t     cw  = '0;
    int unsigned k   = 0;
    logic        par;
    for (int unsigned p = 1; p < MaxCw; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < dw) cw[p[6:0]] = data[k[5:0]];
        k++;
      end
    end
    for (int unsigned j = 0; j < 7; j++) begin
      par = 1'b0;
      for (int unsigned p = 1; p < MaxCw; p++) begin
        if (((p >> j) & 1) != 0) par ^= cw[p[6:0]];
      end
      cw[7'(32'd1 << j)] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/l2_secded_dec.sv
// Combinational SECDED decoder: corrects single-bit errors, flags double-bit errors.
// Unchanged by L2_BANK_ECC_WRITEBACK_EN.
module l2_secded_dec
  import l2_ecc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned CwWidth    = DATA_WIDTH + par_width(DATA_WIDTH)
) (
  input  logic [CwWidth-1:0]    cw_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  corr_o,
  output logic                  uncorr_o
);

  logic [DATA_WIDTH-1:0] raw;
  syndrome_t             syn;
  logic                  overall;
  int                    idx;

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_extract
    localparam int unsigned Pos = data_pos(k);
    assign raw[k] = cw_i[Pos];
  end

  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p < CwWidth; p++) begin
      if (cw_i[p]) syn ^= syndrome_t'(p);
    end
    overall  = ^cw_i;
    corr_o   = overall;
    uncorr_o = !overall && (syn != '0);
    idx      = syn_to_bit(syn);
    data_o   = raw;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (corr_o && (idx == k)) data_o[k] = ~raw[k];
    end
  end

endmodule

// File: rtl/l2_bank_ecc.sv
// Per-bank SECDED + read-modify-write stage in front of one SRAM cut.
// Define L2_BANK_ECC_WRITEBACK_EN to scrub correctable read errors back to memory.
module l2_bank_ecc
  import l2_ecc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned N_WORDS    = 16384,
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(N_WORDS),
  localparam int unsigned PAR_WIDTH  = par_width(DATA_WIDTH),
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned CW_WIDTH   = DATA_WIDTH + PAR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_corr_o,
  output logic                  err_uncorr_o,
  input  logic                  cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [CW_WIDTH-1:0]   sram_wdata_o,
  input  logic [CW_WIDTH-1:0]   sram_rdata_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  rd_q, rd_d;
  logic                  corr_q, corr_d;
  logic                  uncorr_q, uncorr_d;
  logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_WIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_corr;
  logic                  dec_uncorr;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] enc_data;
  logic [CW_WIDTH-1:0]   enc_cw;
  logic                  wb_hold;
  logic                  accept;
  logic                  be_full;
  logic                  be_none;

  l2_secded_dec #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dec (
    .cw_i    (sram_rdata_i),
    .data_o  (dec_data),
    .corr_o  (dec_corr),
    .uncorr_o(dec_uncorr)
  );

  always_comb begin
    be_full = &be_i;
    be_none = ~|be_i;
    wb_hold = 1'b0;
`ifdef L2_BANK_ECC_WRITEBACK_EN
    wb_hold = (state_q == StResp) && rd_q && dec_corr;
`endif
    accept  = ((state_q == StIdle) || (state_q == StResp)) && !wb_hold;
    for (int b = 0; b < int'(BE_WIDTH); b++) begin
      merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : dec_data[8*b +: 8];
    end
    enc_data = wdata_i;
    if (state_q == StMerge) enc_data = merged;
`ifdef L2_BANK_ECC_WRITEBACK_EN
    if (state_q == StWb) enc_data = wdata_q;
`endif
    enc_cw = CW_WIDTH'(secded_encode(data_max_t'(enc_data), DATA_WIDTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (wb_hold) begin
`ifdef L2_BANK_ECC_WRITEBACK_EN
          // Read address is still in addr_q; keep the corrected word for the scrub.
          state_d = StWb;
          wdata_d = dec_data;
`endif
        end else if (req_i) begin
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          be_d     = be_i;
          rd_d     = !we_i;
          corr_d   = 1'b0;
          uncorr_d = 1'b0;
          state_d  = (we_i && !be_full && !be_none) ? StMerge : StResp;
        end
      end
      StMerge: begin
        rd_d     = 1'b0;
        corr_d   = dec_corr;
        uncorr_d = dec_uncorr;
        state_d  = StResp;
      end
`ifdef L2_BANK_ECC_WRITEBACK_EN
      StWb: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_o        = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = addr_i;
    sram_wdata_o = enc_cw;
    rvalid_o     = 1'b0;
    rdata_o      = dec_data;
    err_corr_o   = 1'b0;
    err_uncorr_o = 1'b0;
    if (state_q == StResp) begin
      rvalid_o     = 1'b1;
      err_corr_o   = rd_q ? dec_corr : corr_q;
      err_uncorr_o = rd_q ? dec_uncorr : uncorr_q;
    end
    if (accept && !rst_i) begin
      gnt_o = req_i;
      if (req_i && !(we_i && be_none)) begin
        sram_req_o = 1'b1;
        sram_we_o  = we_i && be_full;
      end
    end
    if (state_q == StMerge) begin
      // An uncorrectable old word must not be overwritten with a guessed merge.
      sram_req_o  = !rst_i && !dec_uncorr;
      sram_we_o   = 1'b1;
      sram_addr_o = addr_q;
    end
`ifdef L2_BANK_ECC_WRITEBACK_EN
    if (state_q == StWb) begin
      sram_req_o  = !rst_i;
      sram_we_o   = 1'b1;
      sram_addr_o = addr_q;
    end
`endif
  end

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (rvalid_o && err_corr_o && !(&corr_cnt_q)) corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
      if (rvalid_o && err_uncorr_o && !(&uncorr_cnt_q)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_l2_bank_ecc.sv
// Directed bench for l2_bank_ecc with a behavioural SRAM and backdoor bit-flip injection.
module tb_l2_bank_ecc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        we;
  logic [13:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err_corr;
  logic        err_uncorr;
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic        sram_req;
  logic        sram_we;
  logic [13:0] sram_addr;
  logic [71:0] sram_wdata;
  logic [71:0] sram_rdata;

  logic [71:0] mem [0:15];
  logic        bd_go = 1'b0;
  logic [3:0]  bd_addr = '0;
  logic [71:0] bd_mask = '0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  localparam logic [63:0] D5 = 64'h0123456789ABCDEF;
  localparam logic [71:0] M17 = 72'h1 << 17;
  localparam logic [71:0] MDBL = (72'h1 << 3) | (72'h1 << 40);

  logic [71:0] cw5;
  logic [71:0] cw7;
  logic [71:0] cw9;

  always #5 clk = ~clk;

  l2_bank_ecc #(
    .DATA_WIDTH(64),
    .N_WORDS   (16384),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_corr_o  (err_corr),
    .err_uncorr_o(err_uncorr),
    .cnt_clr_i   (cnt_clr),
    .corr_cnt_o  (corr_cnt),
    .uncorr_cnt_o(uncorr_cnt),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  always @(posedge clk) begin
    if (bd_go) begin
      mem[bd_addr] <= mem[bd_addr] ^ bd_mask;
    end else if (sram_req) begin
      if (sram_we) mem[sram_addr[3:0]] <= sram_wdata;
      else sram_rdata <= mem[sram_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input logic [3:0] a, input logic [71:0] m);
    bd_addr = a;
    bd_mask = m;
    bd_go   = 1'b1;
    step();
    bd_go   = 1'b0;
  endtask

  task automatic do_write_full(input string tag, input logic [13:0] a, input logic [63:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 8'hFF;
    #1;
    check({tag, "_gnt"}, gnt, 1'b1);
    check({tag, "_sram_we"}, {sram_req, sram_we}, 2'b11);
    step();
    req = 1'b0;
    #1;
    check({tag, "_rvalid"}, {rvalid, err_corr, err_uncorr}, 3'b100);
  endtask

  task automatic do_read(input string tag, input logic [13:0] a, input logic [63:0] d,
                         input logic c, input logic u);
    req = 1'b1; we = 1'b0; addr = a; be = 8'h00;
    #1;
    check({tag, "_gnt"}, gnt, 1'b1);
    check({tag, "_sram_rd"}, {sram_req, sram_we}, 2'b10);
    step();
    req = 1'b0;
    #1;
    check({tag, "_rvalid"}, rvalid, 1'b1);
    check({tag, "_rdata"}, rdata, d);
    check({tag, "_flags"}, {err_corr, err_uncorr}, {c, u});
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0; cnt_clr = 1'b0;
    #3;
    check("rst_gnt", gnt, 1'b0);
    check("rst_sram_req", sram_req, 1'b0);
    check("rst_rvalid", {rvalid, err_corr, err_uncorr}, 3'b000);
    check("rst_cnts", {corr_cnt, uncorr_cnt}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    step();

    // Zero data encodes to the all-zero codeword.
    do_write_full("wr0", 14'd0, 64'h0);
    check("wr0_cw", mem[0], 72'h0);

    do_write_full("wr5", 14'd5, D5);
    do_read("rd5", 14'd5, D5, 1'b0, 1'b0);
    cw5 = mem[5];

    // Zero-enable write: grant, no SRAM access, response next cycle.
    req = 1'b1; we = 1'b1; addr = 14'd5; wdata = 64'h0; be = 8'h00;
    #1;
    check("be0_gnt", gnt, 1'b1);
    check("be0_no_sram", sram_req, 1'b0);
    step();
    req = 1'b0;
    #1;
    check("be0_rvalid", rvalid, 1'b1);
    check("be0_mem", mem[5], cw5);

    // Single-bit error on a data bit.
    flip(4'd5, M17);
    do_read("corr17", 14'd5, D5, 1'b1, 1'b0);
`ifdef L2_BANK_ECC_WRITEBACK_EN
    req = 1'b1;
    #1;
    check("wb_gnt_low", gnt, 1'b0);
    req = 1'b0;
    step();
    step();
    check("wb_repaired", mem[5], cw5);
`else
    step();
    check("corr17_nowb", mem[5], cw5 ^ M17);
    flip(4'd5, M17);
`endif
    check("corr_cnt1", corr_cnt, 16'd1);

    // Double-bit error: raw data bits 0 and 33 come back flipped.
    flip(4'd5, MDBL);
    do_read("dbl", 14'd5, 64'h0123456589ABCDEE, 1'b0, 1'b1);
    step();
    check("dbl_cnts", {corr_cnt, uncorr_cnt}, {16'd1, 16'd1});
    check("dbl_nowb", mem[5], cw5 ^ MDBL);
    flip(4'd5, MDBL);

    // Partial write onto all-ones word, with a read queued behind it.
    do_write_full("wr7", 14'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    req = 1'b1; we = 1'b1; addr = 14'd7; wdata = 64'h0; be = 8'h0F;
    #1;
    check("pw_c0_gnt", gnt, 1'b1);
    check("pw_c0_sram_rd", {sram_req, sram_we}, 2'b10);
    step();
    we = 1'b0; addr = 14'd5; be = 8'h00;
    #1;
    check("pw_c1_gnt", gnt, 1'b0);
    check("pw_c1_sram_wr", {sram_req, sram_we}, 2'b11);
    check("pw_c1_addr", sram_addr, 14'd7);
    check("pw_c1_rvalid", rvalid, 1'b0);
    step();
    #1;
    check("pw_c2_rvalid", {rvalid, err_corr, err_uncorr}, 3'b100);
    check("pw_c2_gnt_next", gnt, 1'b1);
    step();
    req = 1'b0;
    #1;
    check("pw_next_rd", {rvalid, rdata}, {1'b1, D5});
    do_read("rd7", 14'd7, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);

    // Partial write onto a double-error word is suppressed.
    do_write_full("wr9", 14'd9, 64'h1122_3344_5566_7788);
    flip(4'd9, MDBL);
    cw9 = mem[9];
    req = 1'b1; we = 1'b1; addr = 14'd9; wdata = 64'h0; be = 8'h01;
    #1;
    check("pwd_c0_gnt", gnt, 1'b1);
    step();
    req = 1'b0;
    #1;
    check("pwd_c1_nowr", sram_req, 1'b0);
    step();
    check("pwd_c2_resp", {rvalid, err_corr, err_uncorr}, 3'b101);
    step();
    check("pwd_mem", mem[9], cw9);
    check("pwd_ucnt", uncorr_cnt, 16'd2);

`ifndef L2_BANK_ECC_WRITEBACK_EN
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnts", {corr_cnt, uncorr_cnt}, 32'h0);

    // Back-to-back correctable reads drive the counter to saturation.
    flip(4'd5, M17);
    req = 1'b1; we = 1'b0; addr = 14'd5; be = 8'h00;
    repeat (65535) step();
    req = 1'b0;
    step();
    check("sat_full", corr_cnt, 16'hFFFF);
    do_read("sat", 14'd5, D5, 1'b1, 1'b0);
    step();
    check("sat_hold", corr_cnt, 16'hFFFF);
    do_read("clrerr", 14'd5, D5, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_wins", corr_cnt, 16'h0);
    flip(4'd5, M17);
`endif

    // Reset while in MERGE drops the write and its response.
    cw7 = mem[7];
    req = 1'b1; we = 1'b1; addr = 14'd7; wdata = 64'h0; be = 8'hF0;
    #1;
    check("rstm_gnt", gnt, 1'b1);
    step();
    rst = 1'b1; we = 1'b0; addr = 14'd5; be = 8'h00;
    #1;
    check("rstm_sram", {sram_req, gnt, rvalid}, 3'b000);
    step();
    rst = 1'b0; req = 1'b0;
    #1;
    check("rstm_c2", {rvalid, sram_req}, 2'b00);
    step();
    check("rstm_c3", rvalid, 1'b0);
    check("rstm_mem", mem[7], cw7);
    do_read("rd7b", 14'd7, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_bank_ecc.md
# l2_bank_ecc

Per-bank ECC and read-modify-write stage between one bank port of the L2 AXI-to-memory converter and one SRAM cut. It stores each DATA_WIDTH word as a SECDED codeword, corrects single-bit errors and flags double-bit errors on reads, and turns partial byte-enable writes into read-merge-write sequences. Because of this, the upstream bank grant is no longer constant: it is `gnt_o`.

## Interface
- `DATA_WIDTH`, 64: data bits per word; 32 or 64 only.
- `N_WORDS`, 16384: cut depth; power of 2.
- `CNT_WIDTH`, 16: width of the error counters.
- `ADDR_WIDTH` is derived as $clog2(N_WORDS) and is not overridable. `PAR_WIDTH` is taken from the package: 7 for 32-bit data, 8 for 64-bit data.
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `req_i`, in, 1: request valid. It is held until granted.
- `gnt_o`, out, 1: request accepted this cycle.
- `we_i`, in, 1: 1 means write.
- `addr_i`, in, ADDR_WIDTH: word address.
- `wdata_i`, in, DATA_WIDTH: write data.
- `be_i`, in, DATA_WIDTH/8: byte enables.
- `rvalid_o`, out, 1: one-cycle response pulse, one per granted request.
- `rdata_o`, out, DATA_WIDTH: corrected read data. Valid only when `rvalid_o` is high for a read.
- `err_corr_o`, out, 1: qualifies `rvalid_o`; a single-bit error was corrected.
- `err_uncorr_o`, out, 1: qualifies `rvalid_o`; an uncorrectable (double-bit) error was detected.
- `cnt_clr_i`, in, 1: synchronous clear of both counters.
- `corr_cnt_o`, out, CNT_WIDTH: saturating count of corrected errors.
- `uncorr_cnt_o`, out, CNT_WIDTH: saturating count of uncorrectable errors.
- `sram_req_o`, `sram_we_o`, out, 1 each: SRAM request and write enable. Every SRAM write is full-width.
- `sram_addr_o`, out, ADDR_WIDTH: SRAM address.
- `sram_wdata_o`, out, DATA_WIDTH+PAR_WIDTH: codeword to write.
- `sram_rdata_i`, in, DATA_WIDTH+PAR_WIDTH: codeword read. Valid one cycle after a read request.

## Operation
- FSM states: IDLE, RESP, MERGE, WB. In IDLE: `gnt_o = req_i`, and the SRAM signals are driven combinationally from the request.
- Read: granted in cycle 0 and the SRAM read issues in cycle 0. FSM goes to RESP; in cycle 1 the codeword is decoded and `rvalid_o` pulses with `rdata_o` and the error flags.
- Full write (`be_i` all ones): granted in cycle 0 and the encoded codeword is written in cycle 0. `rvalid_o` pulses in cycle 1.
- Partial write (`be_i` neither all ones nor all zeros):
  - Cycle 0: granted; SRAM read of `addr_i`. Address, wdata and be are registered. FSM goes to MERGE.
  - Cycle 1: decode the old word, merge the enabled bytes, write the re-encoded codeword, `gnt_o=0`.
  - Cycle 2: `rvalid_o` pulses.
  - If the old word is uncorrectable: the write is suppressed (no `sram_req_o` in cycle 1), and the cycle-2 response carries `err_uncorr_o=1`. A correctable old word is merged from its corrected value and carries `err_corr_o=1`.
- Zero-enable write (`be_i == 0`): granted, no SRAM access, `rvalid_o` pulses in cycle 1.
- RESP state: `gnt_o = req_i` unless a writeback is required (see Configuration). A new request in RESP is handled as if in IDLE, so back-to-back reads sustain one per cycle.
- Counters:
  - Each counter increments once per response carrying its flag.
  - Counters saturate at all ones.
  - If `cnt_clr_i` and an increment occur in the same cycle, clear wins and the counter reads 0.
- Syndrome with odd overall parity: single-bit error. If the error is in a parity bit, the data is unchanged and `err_corr_o=1`. Syndrome with even overall parity: uncorrectable; `rdata_o` carries the raw data bits.

## Timing
- Read latency: 1 cycle, grant to `rvalid_o`. Partial-write latency: 2 cycles.
- `gnt_o` depends combinationally on `req_i`, the FSM state, and (in RESP) the decode of `sram_rdata_i`.
- Reset values:
  - state IDLE.
  - `rvalid_o`, `err_corr_o`, `err_uncorr_o` = 0.
  - counters 0.
  - registered address/data 0.
  - `gnt_o` and `sram_req_o` = 0 while `rst_i` is high.
- Reset asserted during MERGE or WB: the pending write and its response are dropped, and the FSM restarts in IDLE.

## Configuration
- Macro: `L2_BANK_ECC_WRITEBACK_EN`.
- Defined: a read with a correctable error moves RESP to WB.
  - `gnt_o=0` in that cycle.
  - In the following cycle the corrected codeword is written back to the same address, then the FSM returns to IDLE.
  - The read response itself still appears in cycle 1.
- Undefined: the WB state and its logic are absent. Reads never deassert `gnt_o`, and memory is never rewritten on read.

## Structure
- Package `l2_ecc_pkg` contains:
  - function `par_width(dw)`
  - the codeword typedefs
  - the `secded_encode` function
  - the syndrome-to-bit-position mapping
- Sub-module `l2_secded_dec`: purely combinational. Takes a codeword; produces corrected data, `corr` and `uncorr`. It is instantiated once for read/RMW/WB, on `sram_rdata_i`.

## Test plan
- Full write 0x0123456789ABCDEF to address 5, then read address 5 → read response in cycle 1 with `rdata_o=0x0123456789ABCDEF` and no error flags.
- Flip bit 17 of the stored codeword via backdoor, then read → `rdata_o` correct, `err_corr_o=1`, `corr_cnt_o=1`. With the macro defined: `gnt_o=0` for one cycle and the memory codeword is repaired.
- Flip bits 3 and 40, then read → `err_uncorr_o=1`, `uncorr_cnt_o=1`, no writeback.
- Address 7 holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with `be=0x0F` → SRAM read in cycle 0, write in cycle 1, `rvalid_o` in cycle 2; a later read returns 0xFFFFFFFF00000000.
- Partial write onto a double-error word → no SRAM write, cycle-2 response with `err_uncorr_o=1`, stored word unchanged.
- Preload `corr_cnt_o` to 0xFFFF and inject a correctable error → counter stays at 0xFFFF. `cnt_clr_i` asserted together with an error → counter reads 0. `rst_i` asserted in MERGE → no SRAM write and no `rvalid_o`.
